// File: rtl/t07_fxp_pkg.sv
// t07_fxp_pkg: shared op/state encodings and saturation limits for the fixed-point arithmetic unit
package t07_fxp_pkg;

   typedef enum logic [2:0] {
      OP_ADD,
      OP_SUB,
      OP_MUL,
      OP_DIV,
      OP_MIN,
      OP_MAX
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   // Limits are built at MAX_W bits and cut down to WIDTH by the user, so WIDTH <= MAX_W.
   localparam int MAX_W = 64;

   function automatic logic [MAX_W-1:0] max_pos(input int w);
      return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
   endfunction

   function automatic logic [MAX_W-1:0] min_neg(input int w);
      return MAX_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/t07_fxp_divider.sv
// t07_fxp_divider: iterative restoring divider, one quotient bit per cycle over WIDTH+FRAC cycles
// Ports: clk, nrst (sync active-low); start_i loads dividend_i/divisor_i; done_o is high during the
// final iteration cycle, with quotient_o carrying the complete quotient in that same cycle.
module t07_fxp_divider #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start_i,
   input  logic [WIDTH+FRAC-1:0] dividend_i,
   input  logic [WIDTH-1:0]      divisor_i,
   output logic                  done_o,
   output logic [WIDTH+FRAC-1:0] quotient_o
);

   localparam int NW = WIDTH + FRAC;
   localparam int CW = $clog2(NW);

   logic          busy_q;
   logic [CW-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q, rem_d, dv_q;
   logic [NW-1:0] dq_q, dq_d;
   logic [WIDTH:0] sh;
   logic ge;

   // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom.
   assign sh = {rem_q, dq_q[NW-1]};
   assign ge = sh >= {1'b0, dv_q};
   assign rem_d = ge ? WIDTH'(sh - {1'b0, dv_q}) : sh[WIDTH-1:0];
   assign dq_d = {dq_q[NW-2:0], ge};
   assign done_o = busy_q && cnt_q == CW'(NW - 1);
   assign quotient_o = dq_d;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         dq_q   <= '0;
         dv_q   <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         rem_q  <= '0;
         dq_q   <= dividend_i;
         dv_q   <= divisor_i;
      end else if (busy_q) begin
         rem_q  <= rem_d;
         dq_q   <= dq_d;
         cnt_q  <= cnt_q + CW'(1);
         busy_q <= !done_o;
      end
   end

endmodule

// File: rtl/t07_fxp_arith_unit.sv
// t07_fxp_arith_unit: multi-cycle signed Q fixed-point add/sub/min/max/mul/div behind valid/ready
// Ports: clk, nrst (sync active-low); in_valid/in_ready/op/val_a/val_b issue side;
// out_valid/out_ready/result/ovf_flag/dz_flag/zero_flag result side, held until out_ready.
module t07_fxp_arith_unit
   import t07_fxp_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] val_a,
   input  logic [WIDTH-1:0] val_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             ovf_flag,
   output logic             dz_flag,
   output logic             zero_flag
);

   localparam int NW = WIDTH + FRAC;
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(max_pos(WIDTH));
   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(min_neg(WIDTH));
   localparam logic [PW-1:0] LIM_P = PW'(MAX_V);
   localparam logic [PW-1:0] LIM_N = PW'(MIN_V);

   state_t state_q, state_d;
   logic [PW-1:0] ma_q, ma_d, prod_q, prod_d, prod_nxt, fm;
   logic [WIDTH-1:0] mb_q, mb_d, res_q, res_d, abs_a, abs_b, s_res, f_res, f_wrap;
   logic [CW-1:0] cnt_q, cnt_d;
   logic sign_q, sign_d, ovf_q, ovf_d, dz_q, dz_d, zf_q, zf_d;
   logic [WIDTH:0] sum;
   logic s_ovf, s_dz, f_ovf, accept, div_start, div_done;
   logic [NW-1:0] div_dvd, div_quo;

   assign accept = in_valid && in_ready;
   // Magnitudes as unsigned WIDTH bits, so |MIN| = 2^(WIDTH-1) is exact.
   assign abs_a = val_a[WIDTH-1] ? -val_a : val_a;
   assign abs_b = val_b[WIDTH-1] ? -val_b : val_b;
   assign div_start = accept && op == OP_DIV && |val_b;
   assign div_dvd = NW'(abs_a) << FRAC;

   t07_fxp_divider #(.WIDTH(WIDTH), .FRAC(FRAC)) u_div (
      .clk       (clk),
      .nrst      (nrst),
      .start_i   (div_start),
      .dividend_i(div_dvd),
      .divisor_i (abs_b),
      .done_o    (div_done),
      .quotient_o(div_quo)
   );

   always_comb begin
      sum = op == OP_SUB ? {val_a[WIDTH-1], val_a} - {val_b[WIDTH-1], val_b}
                         : {val_a[WIDTH-1], val_a} + {val_b[WIDTH-1], val_b};
      s_res = '0;
      s_ovf = 1'b0;
      s_dz  = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            s_ovf = sum[WIDTH] ^ sum[WIDTH-1];
            s_res = s_ovf && SATURATE ? (sum[WIDTH] ? MIN_V : MAX_V) : sum[WIDTH-1:0];
         end
         OP_MIN: s_res = $signed(val_a) <= $signed(val_b) ? val_a : val_b;
         OP_MAX: s_res = $signed(val_a) >= $signed(val_b) ? val_a : val_b;
         // Only reaches DONE from here when val_b == 0; nonzero divisors go through the divider.
         OP_DIV: begin
            s_dz  = 1'b1;
            s_res = val_a[WIDTH-1] ? MIN_V : |val_a ? MAX_V : '0;
         end
         default: ;
      endcase
   end

   // Shared finalisation of MUL/DIV magnitudes: scale, overflow test against the signed limits, sign.
   assign prod_nxt = prod_q + (mb_q[0] ? ma_q : '0);
   assign fm = state_q == MUL ? prod_nxt >> FRAC : PW'(div_quo);
   assign f_ovf = fm > (sign_q ? LIM_N : LIM_P);
   assign f_wrap = WIDTH'(sign_q ? -fm : fm);
   assign f_res = f_ovf && SATURATE ? (sign_q ? MIN_V : MAX_V) : f_wrap;

   always_comb begin
      state_d = state_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      zf_d    = zf_q;
      case (state_q)
         IDLE: if (accept) begin
            sign_d = val_a[WIDTH-1] ^ val_b[WIDTH-1];
            ma_d   = PW'(abs_a);
            mb_d   = abs_b;
            prod_d = '0;
            cnt_d  = '0;
            if (op == OP_MUL) state_d = MUL;
            else if (div_start) state_d = DIV;
            else begin
               state_d = DONE;
               res_d   = s_res;
               ovf_d   = s_ovf;
               dz_d    = s_dz;
               zf_d    = ~|s_res;
            end
         end
         MUL: begin
            prod_d = prod_nxt;
            ma_d   = ma_q << 1;
            mb_d   = mb_q >> 1;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               res_d   = f_res;
               ovf_d   = f_ovf;
               dz_d    = 1'b0;
               zf_d    = ~|f_res;
            end
         end
         DIV: if (div_done) begin
            state_d = DONE;
            res_d   = f_res;
            ovf_d   = f_ovf;
            dz_d    = 1'b0;
            zf_d    = ~|f_res;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= IDLE;
         ma_q    <= '0;
         mb_q    <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
         zf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
         zf_q    <= zf_d;
      end
   end

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign result    = res_q;
   assign ovf_flag  = ovf_q;
   assign dz_flag   = dz_q;
   assign zero_flag = zf_q;

endmodule

// File: tb/tb_t07_fxp_arith_unit.sv
// tb_t07_fxp_arith_unit: directed checks of the fixed-point unit, saturating and wrapping builds
module tb_t07_fxp_arith_unit;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [2:0] op = '0;
   logic [31:0] val_a = '0, val_b = '0;
   logic ir0, ov0, of0, dz0, zf0, ir1, ov1, of1, dz1, zf1;
   logic [31:0] r0, r1;
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   t07_fxp_arith_unit #(.WIDTH(32), .FRAC(16), .SATURATE(1'b1)) dut0 (
      .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(ir0), .op(op),
      .val_a(val_a), .val_b(val_b), .out_valid(ov0), .out_ready(out_ready),
      .result(r0), .ovf_flag(of0), .dz_flag(dz0), .zero_flag(zf0)
   );

   t07_fxp_arith_unit #(.WIDTH(32), .FRAC(16), .SATURATE(1'b0)) dut1 (
      .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(ir1), .op(op),
      .val_a(val_a), .val_b(val_b), .out_valid(ov1), .out_ready(out_ready),
      .result(r1), .ovf_flag(of1), .dz_flag(dz1), .zero_flag(zf1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic eo, input logic ed, input logic [31:0] er1,
                      input int lat);
      int n;
      op = o;
      val_a = a;
      val_b = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      val_a = ~a;
      val_b = ~b;
      op = 3'd7;
      n = 1;
      while (!ov0 && n < 200) begin
         tick();
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(lat));
      chk({tag, " result"}, 64'(r0), 64'(er));
      chk({tag, " ovf"}, 64'(of0), 64'(eo));
      chk({tag, " dz"}, 64'(dz0), 64'(ed));
      chk({tag, " zero"}, 64'(zf0), 64'(er == 32'd0));
      chk({tag, " in_ready busy"}, 64'(ir0), 64'd0);
      chk({tag, " wrap result"}, 64'(r1), 64'(er1));
      chk({tag, " wrap ovf"}, 64'(of1), 64'(eo));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " released"}, 64'({ov0, ir0}), 64'b01);
   endtask

   initial begin
      int seen;
      logic [31:0] held;
      tick();
      tick();
      nrst = 1'b1;
      chk("reset out_valid", 64'(ov0), 64'd0);
      chk("reset result", 64'(r0), 64'd0);
      chk("reset flags", 64'({of0, dz0, zf0}), 64'd0);
      chk("reset in_ready", 64'(ir0), 64'd1);

      run("mul 1.5*2", 3'd2, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b0, 32'h0003_0000, 33);
      run("div 1/4", 3'd3, 32'h0001_0000, 32'h0004_0000, 32'h0000_4000, 1'b0, 1'b0, 32'h0000_4000, 49);
      run("div -1/0", 3'd3, 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1);
      run("div 0/0", 3'd3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1);
      run("add ovf", 3'd0, 32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h8001_0000, 1);
      run("mul -0.5*1", 3'd2, 32'hFFFF_8000, 32'h0001_0000, 32'hFFFF_8000, 1'b0, 1'b0, 32'hFFFF_8000, 33);
      run("sub zero", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1);
      run("min signed", 3'd4, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0, 1'b0, 32'hFFFF_0000, 1);
      run("mul min*min", 3'd2, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 33);
      run("div -1/3", 3'd3, 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, 32'hFFFF_AAAB, 49);
      run("div ovf", 3'd3, 32'h7FFF_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'hFFFE_0000, 49);
      run("reserved", 3'd6, 32'h1234_5678, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1);

      op = 3'd5;
      val_a = 32'h0003_0000;
      val_b = 32'hFFFE_0000;
      in_valid = 1'b1;
      tick();
      op = 3'd0;
      val_a = 32'h0000_1000;
      val_b = 32'h0000_2000;
      held = r0;
      chk("max result", 64'(r0), 64'h0003_0000);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall out_valid", 64'(ov0), 64'd1);
         chk("stall result", 64'(r0), 64'(held));
         chk("stall in_ready", 64'(ir0), 64'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      tick();
      chk("stall input dropped", 64'({ov0, ir0}), 64'b01);

      op = 3'd3;
      val_a = 32'h0001_0000;
      val_b = 32'h0004_0000;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      seen = 0;
      for (int i = 1; i < 20; i++) begin
         tick();
         if (ov0) seen++;
      end
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      chk("abort in_ready", 64'(ir0), 64'd1);
      chk("abort out_valid", 64'(ov0), 64'd0);
      for (int i = 0; i < 60; i++) begin
         tick();
         if (ov0) seen++;
      end
      chk("abort no output", 64'(seen), 64'd0);
      run("add after abort", 3'd0, 32'h0001_8000, 32'hFFFF_C000, 32'h0001_4000, 1'b0, 1'b0, 32'h0001_4000, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
